decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 100 ++++++++++
 rtl/decode_comb.sv | 130 +++++++++++++
 rtl/decode_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode types: opcodes, format codes, ALU operations and the decoded entry.
// No logic here; purely combinational helpers.
// Used by decode_comb and decode_stage.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // FMT_NONE is zero so an all-zero entry reads as "no format".
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_t;

    // M-extension codes always exist so downstream units see one stable encoding.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_EQ     = 5'd11,
        ALU_NE     = 5'd12,
        ALU_LT     = 5'd13,
        ALU_GE     = 5'd14,
        ALU_LTU    = 5'd15,
        ALU_GEU    = 5'd16,
        ALU_MUL    = 5'd17,
        ALU_MULH   = 5'd18,
        ALU_MULHSU = 5'd19,
        ALU_MULHU  = 5'd20,
        ALU_DIV    = 5'd21,
        ALU_DIVU   = 5'd22,
        ALU_REM    = 5'd23,
        ALU_REMU   = 5'd24
    } alu_op_t;

    // Immediate is kept at 32 bits; the stage sign-extends to XLEN at its output.
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        fmt_t        fmt;
        alu_op_t     alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_t;

    // funct3 -> operation for the base register/immediate arithmetic group.
    function automatic alu_op_t base_alu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // funct3 -> operation for the multiply/divide group.
    function automatic alu_op_t m_alu_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I decode of one instruction word into a dec_t entry.
// Latency 0; no handshake, no backpressure.
// DECODE_RV32M_EN defined: funct7=0000001 OP encodings decode as M ops, else illegal.
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        bad;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Per-opcode field selection; any unsupported encoding collapses to a bare illegal entry.
    always_comb begin
        dec_o = '0;
        bad   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_o.fmt = FMT_U; dec_o.rd = rd; dec_o.imm = imm_u;
                dec_o.alu_op = ALU_PASSB; dec_o.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.fmt = FMT_U; dec_o.rd = rd; dec_o.imm = imm_u;
                dec_o.alu_op = ALU_ADD; dec_o.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec_o.fmt = FMT_J; dec_o.rd = rd; dec_o.imm = imm_j;
                dec_o.alu_op = ALU_ADD; dec_o.reg_write = 1'b1; dec_o.jump = 1'b1;
            end
            OPC_JALR: begin
                dec_o.fmt = FMT_I; dec_o.rd = rd; dec_o.rs1 = rs1; dec_o.imm = imm_i;
                dec_o.alu_op = ALU_ADD; dec_o.reg_write = 1'b1; dec_o.jump = 1'b1;
                bad = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec_o.fmt = FMT_B; dec_o.rs1 = rs1; dec_o.rs2 = rs2; dec_o.imm = imm_b;
                dec_o.branch = 1'b1;
                case (funct3)
                    3'b000:  dec_o.alu_op = ALU_EQ;
                    3'b001:  dec_o.alu_op = ALU_NE;
                    3'b100:  dec_o.alu_op = ALU_LT;
                    3'b101:  dec_o.alu_op = ALU_GE;
                    3'b110:  dec_o.alu_op = ALU_LTU;
                    3'b111:  dec_o.alu_op = ALU_GEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_o.fmt = FMT_I; dec_o.rd = rd; dec_o.rs1 = rs1; dec_o.imm = imm_i;
                dec_o.alu_op = ALU_ADD; dec_o.reg_write = 1'b1; dec_o.mem_read = 1'b1;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
                    default:                                bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_o.fmt = FMT_S; dec_o.rs1 = rs1; dec_o.rs2 = rs2; dec_o.imm = imm_s;
                dec_o.alu_op = ALU_ADD; dec_o.mem_write = 1'b1;
                bad = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec_o.fmt = FMT_I; dec_o.rd = rd; dec_o.rs1 = rs1; dec_o.imm = imm_i;
                dec_o.reg_write = 1'b1;
                dec_o.alu_op = base_alu_op(funct3);
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (funct3 == 3'b001) begin
                    bad = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000) begin
                        dec_o.alu_op = ALU_SRA;
                    end else begin
                        bad = (funct7 != 7'b0000000);
                    end
                end
            end
            OPC_OP: begin
                dec_o.fmt = FMT_R; dec_o.rd = rd; dec_o.rs1 = rs1; dec_o.rs2 = rs2;
                dec_o.reg_write = 1'b1;
                case (funct7)
                    7'b0000000: dec_o.alu_op = base_alu_op(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            dec_o.alu_op = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            dec_o.alu_op = ALU_SRA;
                        end else begin
                            bad = 1'b1;
                        end
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: dec_o.alu_op = m_alu_op(funct3);
`else
                    7'b0000001: bad = 1'b1;
`endif
                    default:    bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec_o         = '0;
            dec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: output register plus one skid entry around decode_comb.
// Latency 1 cycle from input transfer to out_valid; 1 instr/cycle sustained.
// in_ready is registered (low only when the skid entry is occupied); DECODE_RV32M_EN enables M decode.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ILLEGAL_PASS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [4:0]      out_alu_op,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    dec_t            out_q, out_d, skid_q, skid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic            in_ready_q;
    dec_t            dec;
    logic            in_xfer;
    logic            out_xfer;
    logic            store;

    decode_comb u_decode_comb (
        .instr_i (in_instr),
        .dec_o   (dec)
    );

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid && out_ready;
    // Dropped illegal instructions still complete the input handshake.
    assign store    = in_xfer && !flush && ((ILLEGAL_PASS != 0) || !dec.illegal);

    // Next-state and storage steering; flush overrides every handshake event.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        out_pc_d  = out_pc_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (store) begin
                        state_d  = S_FULL;
                        out_d    = dec;
                        out_pc_d = in_pc;
                    end
                end
                S_FULL: begin
                    if (out_xfer) begin
                        if (store) begin
                            out_d    = dec;
                            out_pc_d = in_pc;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end else if (store) begin
                        state_d   = S_SKID;
                        skid_d    = dec;
                        skid_pc_d = in_pc;
                    end
                end
                S_SKID: begin
                    if (out_xfer) begin
                        state_d  = S_FULL;
                        out_d    = skid_q;
                        out_pc_d = skid_pc_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State, storage and registered in_ready; reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            out_q      <= '0;
            out_pc_q   <= '0;
            skid_q     <= '0;
            skid_pc_q  <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            out_pc_q   <= out_pc_d;
            skid_q     <= skid_d;
            skid_pc_q  <= skid_pc_d;
            in_ready_q <= (state_d != S_SKID);
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != S_EMPTY);
    assign out_pc        = out_pc_q;
    assign out_rd        = out_q.rd;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_imm       = XLEN'($signed(out_q.imm));
    assign out_fmt       = out_q.fmt;
    assign out_alu_op    = out_q.alu_op;
    assign out_reg_write = out_q.reg_write;
    assign out_mem_read  = out_q.mem_read;
    assign out_mem_write = out_q.mem_write;
    assign out_branch    = out_q.branch;
    assign out_jump      = out_q.jump;
    assign out_illegal   = out_q.illegal;

endmodule
